// File: rtl/world_update_pkg.sv
// Shared definitions for the world-update and collision stages: entry layout,
// type codes and the top-level game state encoding.
package world_update_pkg;

    localparam int DATALEN   = 40;
    localparam int DATACOUNT = 8;

    localparam int TYPE_START = 36;
    localparam int TYPE_LEN   = 4;
    localparam int X_START    = 26;
    localparam int X_LEN      = 10;
    localparam int Y_START    = 16;
    localparam int Y_LEN      = 10;
    localparam int W_START    = 8;
    localparam int W_LEN      = 8;
    localparam int H_START    = 0;
    localparam int H_LEN      = 8;

    localparam logic [3:0] T_EMPTY  = 4'd0;
    localparam logic [3:0] T_GROUND = 4'd1;
    localparam logic [3:0] T_RISE   = 4'd2;
    localparam logic [3:0] T_FALL   = 4'd3;
    localparam logic [3:0] T_ENEMY  = 4'd4;

    localparam logic [9:0] PLAYER_X    = 10'd32;
    localparam logic [7:0] PLAYER_SIZE = 8'd16;

    // Field order matches the *_START constants above (type in the MSBs).
    typedef struct packed {
        logic [3:0] kind;
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] w;
        logic [7:0] h;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } game_state_t;

    localparam entry_t PLAYER_INIT = '{kind: T_GROUND, x: PLAYER_X, y: 10'd0,
                                       w: PLAYER_SIZE, h: PLAYER_SIZE};

    function automatic entry_t init_entry(input int idx);
        return (idx == 0) ? PLAYER_INIT : entry_t'('0);
    endfunction

endpackage

// File: rtl/world_update_lfsr16.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), seeded with 0xACE1,
// stepping once for every cycle en is high.
module lfsr16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [15:0] q
);

    logic fb;

    assign fb = q[0] ^ q[2] ^ q[3] ^ q[5];

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= 16'hACE1;
        end else if (en) begin
            q <= {fb, q[15:1]};
        end
    end

endmodule

// File: rtl/world_update.sv
// Per-frame world update: player jump physics, enemy scrolling and spawning,
// score keeping, and the IDLE/RUN/OVER game state machine.
module world_update
    import world_update_pkg::*;
#(
    parameter int SCREEN_W  = 640,
    parameter int SPEED     = 4,
    parameter int JUMP_V    = 12,
    parameter int SPAWN_MIN = 40
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          frame_tick,
    input  logic                          run,
    input  logic                          jump,
    input  logic                          collide,
    output logic [DATALEN*DATACOUNT-1:0]  gamedata,
    output logic                          updated,
    output logic                          game_over,
    output logic [15:0]                   score
);

    game_state_t state, state_nx;
    logic        vld_p0, vld_p1, reload;

    entry_t      ent    [DATACOUNT];
    entry_t      ent_p0 [DATACOUNT];
    logic [7:0]  vy, vy_p0, vy_inc;
    logic [15:0] spawn_cnt, spawn_cnt_p0, cnt_inc;
    logic [15:0] lfsr_q;
    logic        spawned;
    entry_t      spawn_ent;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (vld_p0),
        .q     (lfsr_q)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // run=0 wins over a tick; a colliding tick ends the run without committing.
    always_comb begin
        state_nx = state;
        vld_p0   = 1'b0;
        reload   = 1'b0;
        case (state)
            ST_IDLE: if (run) state_nx = ST_RUN;
            ST_RUN: begin
                if (!run) begin
                    state_nx = ST_IDLE;
                    reload   = 1'b1;
                end else if (frame_tick && collide) begin
                    state_nx = ST_OVER;
                end else if (frame_tick) begin
                    vld_p0 = 1'b1;
                end
            end
            ST_OVER: begin
                if (!run) begin
                    state_nx = ST_IDLE;
                    reload   = 1'b1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                reload   = 1'b1;
            end
        endcase
    end

    assign game_over = (state == ST_OVER);
    assign vy_inc    = vy + 8'd1;
    assign cnt_inc   = spawn_cnt + 16'd1;
    assign spawn_ent = '{kind: T_ENEMY, x: 10'(SCREEN_W), y: 10'd0,
                         w: lfsr_q[4] ? 8'd8  : 8'd16,
                         h: lfsr_q[4] ? 8'd24 : 8'd16};

    // Stage p0: next world image computed from the registered image.
    always_comb begin
        for (int i = 0; i < DATACOUNT; i++) ent_p0[i] = ent[i];
        vy_p0        = vy;
        spawn_cnt_p0 = cnt_inc;
        spawned      = 1'b0;

        case (ent[0].kind)
            T_GROUND: begin
                if (jump) begin
                    ent_p0[0].y    = ent[0].y + 10'(JUMP_V);
                    vy_p0          = 8'(JUMP_V - 1);
                    ent_p0[0].kind = (JUMP_V == 1) ? T_FALL : T_RISE;
                end
            end
            T_RISE: begin
                ent_p0[0].y = ent[0].y + {2'b00, vy};
                vy_p0       = vy - 8'd1;
                if (vy == 8'd1) ent_p0[0].kind = T_FALL;
            end
            T_FALL: begin
                vy_p0 = vy_inc;
                if (ent[0].y <= {2'b00, vy_inc}) begin
                    ent_p0[0].y    = 10'd0;
                    ent_p0[0].kind = T_GROUND;
                    vy_p0          = 8'd0;
                end else begin
                    ent_p0[0].y = ent[0].y - {2'b00, vy_inc};
                end
            end
            default: ;
        endcase

        for (int i = 1; i < DATACOUNT; i++) begin
            if (ent[i].kind != T_EMPTY) begin
                if (ent[i].x < 10'(SPEED)) ent_p0[i] = '0;
                else                       ent_p0[i].x = ent[i].x - 10'(SPEED);
            end
        end

        // Free-slot search looks at the pre-move image, so a slot expiring
        // this frame is not reused until the next spawn.
        if (int'(cnt_inc) >= SPAWN_MIN + int'(lfsr_q[3:0])) begin
            spawn_cnt_p0 = 16'd0;
            for (int i = 1; i < DATACOUNT; i++) begin
                if (!spawned && ent[i].kind == T_EMPTY) begin
                    ent_p0[i] = spawn_ent;
                    spawned   = 1'b1;
                end
            end
        end
    end

    // Stage p1: committed image, score and update pulse.
    always_ff @(posedge clk) begin
        if (!reset || reload) begin
            for (int i = 0; i < DATACOUNT; i++) ent[i] <= init_entry(i);
            vy        <= 8'd0;
            spawn_cnt <= 16'd0;
            score     <= 16'd0;
        end else if (vld_p0) begin
            for (int i = 0; i < DATACOUNT; i++) ent[i] <= ent_p0[i];
            vy        <= vy_p0;
            spawn_cnt <= spawn_cnt_p0;
            if (score != 16'hFFFF) score <= score + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
        end
    end

    assign updated = vld_p1;

    always_comb begin
        for (int i = 0; i < DATACOUNT; i++) gamedata[i*DATALEN +: DATALEN] = ent[i];
    end

endmodule

// File: tb/tb_world_update.sv
// Randomised scoreboard bench for world_update: a default-parameter instance
// plus a fast-spawn instance that fills every enemy slot.
module tb_world_update;

    typedef struct packed {
        logic [319:0] gd;
        logic [15:0]  sc;
    } exp_t;

    logic clk = 1'b0;
    logic reset, run, tick, jump, collide;
    logic [319:0] gd0, gd1;
    logic [15:0]  sc0, sc1;
    logic upd0, upd1, go0, go1;

    int n_cmp = 0;
    int n_err = 0;

    exp_t q0[$];
    exp_t q1[$];

    // Behavioural model state, one set per instance.
    int       m_state [2];   // 0 idle, 1 run, 2 over
    int       m_ptype [2];
    int       m_py    [2];
    int       m_vy    [2];
    bit       m_act   [2][8];
    int       m_ex    [2][8];
    int       m_ew    [2][8];
    int       m_eh    [2][8];
    int       m_cnt   [2];
    int       m_score [2];
    bit [15:0] m_lfsr [2];
    bit       skip_now[2];

    always #5 clk = ~clk;

    world_update dut0 (
        .clk(clk), .reset(reset), .frame_tick(tick), .run(run), .jump(jump),
        .collide(collide), .gamedata(gd0), .updated(upd0), .game_over(go0), .score(sc0)
    );

    world_update #(.SCREEN_W(640), .SPEED(1), .JUMP_V(12), .SPAWN_MIN(1)) dut1 (
        .clk(clk), .reset(reset), .frame_tick(tick), .run(run), .jump(jump),
        .collide(collide), .gamedata(gd1), .updated(upd1), .game_over(go1), .score(sc1)
    );

    function automatic int spd(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic int smin(input int k);
        return (k == 0) ? 40 : 1;
    endfunction

    function automatic logic [39:0] mk(input int kind, input int x, input int y, input int w, input int h);
        return {4'(kind), 10'(x), 10'(y), 8'(w), 8'(h)};
    endfunction

    function automatic logic [319:0] init_img();
        logic [319:0] g;
        g = '0;
        g[39:0] = mk(1, 32, 0, 16, 16);
        return g;
    endfunction

    function automatic logic [39:0] slot(input logic [319:0] g, input int i);
        return g[i*40 +: 40];
    endfunction

    function automatic logic [319:0] img(input int k);
        logic [319:0] g;
        g = '0;
        g[39:0] = mk(m_ptype[k], 32, m_py[k], 16, 16);
        for (int i = 1; i < 8; i++)
            if (m_act[k][i]) g[i*40 +: 40] = mk(4, m_ex[k][i], 0, m_ew[k][i], m_eh[k][i]);
        return g;
    endfunction

    task automatic m_init(input int k);
        m_ptype[k] = 1; m_py[k] = 0; m_vy[k] = 0;
        for (int i = 0; i < 8; i++) m_act[k][i] = 1'b0;
        m_cnt[k] = 0; m_score[k] = 0;
    endtask

    task automatic m_tick(input int k, input bit jp);
        bit was_free[8];
        bit found;
        if (m_ptype[k] == 1 && jp) begin
            m_vy[k] = 12; m_ptype[k] = 2;
        end
        if (m_ptype[k] == 2) begin
            m_py[k] += m_vy[k]; m_vy[k] -= 1;
            if (m_vy[k] == 0) m_ptype[k] = 3;
        end else if (m_ptype[k] == 3) begin
            m_vy[k] += 1;
            if (m_py[k] <= m_vy[k]) begin m_py[k] = 0; m_ptype[k] = 1; m_vy[k] = 0; end
            else m_py[k] -= m_vy[k];
        end
        for (int i = 1; i < 8; i++) begin
            was_free[i] = !m_act[k][i];
            if (m_act[k][i]) begin
                if (m_ex[k][i] < spd(k)) m_act[k][i] = 1'b0;
                else m_ex[k][i] -= spd(k);
            end
        end
        m_cnt[k] += 1;
        if (m_cnt[k] >= smin(k) + int'(m_lfsr[k][3:0])) begin
            m_cnt[k] = 0;
            found = 1'b0;
            for (int i = 1; i < 8; i++) begin
                if (!found && was_free[i]) begin
                    found = 1'b1;
                    m_act[k][i] = 1'b1; m_ex[k][i] = 640;
                    m_ew[k][i] = m_lfsr[k][4] ? 8 : 16;
                    m_eh[k][i] = m_lfsr[k][4] ? 24 : 16;
                end
            end
            if (!found) skip_now[k] = 1'b1;
        end
        if (m_score[k] < 65535) m_score[k] += 1;
        m_lfsr[k] = {m_lfsr[k][0] ^ m_lfsr[k][2] ^ m_lfsr[k][3] ^ m_lfsr[k][5], m_lfsr[k][15:1]};
    endtask

    task automatic m_step(input int k, input bit rs, input bit rn, input bit tk,
                          input bit jp, input bit cl, output bit commit);
        exp_t e;
        commit = 1'b0;
        skip_now[k] = 1'b0;
        if (!rs) begin
            m_init(k); m_state[k] = 0; m_lfsr[k] = 16'hACE1;
        end else if (m_state[k] == 0) begin
            if (rn) m_state[k] = 1;
        end else if (!rn) begin
            m_init(k); m_state[k] = 0;
        end else if (m_state[k] == 1 && tk && cl) begin
            m_state[k] = 2;
        end else if (m_state[k] == 1 && tk) begin
            m_tick(k, jp);
            commit = 1'b1;
            e.gd = img(k); e.sc = 16'(m_score[k]);
            if (k == 0) q0.push_back(e); else q1.push_back(e);
        end
    endtask

    task automatic chk_v(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_g(input string nm, input logic [319:0] act, input logic [319:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input bit rs, input bit rn, input bit tk, input bit jp, input bit cl);
        bit c0, c1;
        reset = rs; run = rn; tick = tk; jump = jp; collide = cl;
        m_step(0, rs, rn, tk, jp, cl, c0);
        m_step(1, rs, rn, tk, jp, cl, c1);
        @(posedge clk); #1;
        chk_v("updated0", int'(upd0), int'(c0));
        chk_v("updated1", int'(upd1), int'(c1));
        if (skip_now[1]) chk_g("full_slots_skip", gd1, img(1));
    endtask

    // One tick in RUN (run=1, no collision), preceded by a random idle gap.
    task automatic tick_once(input bit jp);
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) step(1, 1, 0, jp, 0);
        step(1, 1, 1, jp, 0);
    endtask

    // Scoreboard monitor: every updated pulse pops one expected image.
    always @(negedge clk) begin
        exp_t e;
        if (upd0 === 1'b1) begin
            n_cmp++;
            if (q0.size() == 0) begin
                n_err++; $display("FAIL sb0_unexpected: updated=1 expected no pulse");
            end else begin
                e = q0.pop_front();
                if (gd0 !== e.gd || sc0 !== e.sc) begin
                    n_err++;
                    $display("FAIL sb0_image: got %h/%0d expected %h/%0d", gd0, sc0, e.gd, e.sc);
                end
            end
        end
        if (upd1 === 1'b1) begin
            n_cmp++;
            if (q1.size() == 0) begin
                n_err++; $display("FAIL sb1_unexpected: updated=1 expected no pulse");
            end else begin
                e = q1.pop_front();
                if (gd1 !== e.gd || sc1 !== e.sc) begin
                    n_err++;
                    $display("FAIL sb1_image: got %h/%0d expected %h/%0d", gd1, sc1, e.gd, e.sc);
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL timeout: simulation bound expired");
        $fatal(1, "timeout");
    end

    initial begin
        int maxy;
        int n;
        logic [39:0] s;

        // Reset and init image.
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk_g("reset_image", gd0, init_img());
        chk_v("reset_score", int'(sc0), 0);
        chk_v("reset_updated", int'(upd0), 0);
        chk_v("reset_game_over", int'(go0), 0);

        // Start, first jump tick.
        step(1, 1, 0, 0, 0);
        step(1, 1, 1, 1, 0);
        s = slot(gd0, 0);
        chk_v("jump1_type", int'(s[39:36]), 2);
        chk_v("jump1_y", int'(s[25:16]), 12);
        chk_v("jump1_score", int'(sc0), 1);
        step(1, 1, 0, 0, 0);

        // Rise to the peak with jump held.
        maxy = 12;
        for (int t = 2; t <= 12; t++) begin
            tick_once(1);
            s = slot(gd0, 0);
            if (int'(s[25:16]) > maxy) maxy = int'(s[25:16]);
            if (t == 2) chk_v("rise2_y", int'(s[25:16]), 23);
        end
        s = slot(gd0, 0);
        chk_v("peak_y", int'(s[25:16]), 78);
        chk_v("peak_type", int'(s[39:36]), 3);

        // Fall back to ground, jump still held.
        for (int t = 1; t <= 12; t++) begin
            tick_once(1);
            s = slot(gd0, 0);
            if (int'(s[25:16]) > maxy) maxy = int'(s[25:16]);
            if (t == 1) chk_v("fall1_y", int'(s[25:16]), 77);
        end
        s = slot(gd0, 0);
        chk_v("max_height", maxy, 78);
        chk_v("land_y", int'(s[25:16]), 0);
        chk_v("land_type", int'(s[39:36]), 1);

        // First spawn and its full traverse.
        n = 0;
        while (!m_act[0][1] && n < 100) begin
            tick_once(1'($urandom_range(0, 1)));
            n++;
        end
        s = slot(gd0, 1);
        chk_v("spawn_type", int'(s[39:36]), 4);
        chk_v("spawn_x", int'(s[35:26]), 640);
        for (int t = 0; t < 160; t++) tick_once(1'($urandom_range(0, 1)));
        s = slot(gd0, 1);
        chk_v("edge_type", int'(s[39:36]), 4);
        chk_v("edge_x", int'(s[35:26]), 0);
        tick_once(0);
        chk_g("expire_slot", {280'd0, slot(gd0, 1)}, 320'd0);

        // Collision then frozen OVER, then back to IDLE.
        step(1, 1, 1, 0, 1);
        chk_v("over_flag", int'(go0), 1);
        chk_g("over_image", gd0, img(0));
        for (int t = 0; t < 5; t++) step(1, 1, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        chk_g("frozen_image", gd0, img(0));
        chk_v("frozen_score", int'(sc0), m_score[0]);
        chk_v("frozen_flag", int'(go0), 1);
        step(1, 0, 0, 0, 0);
        chk_g("idle_image", gd0, init_img());
        chk_v("idle_score", int'(sc0), 0);
        chk_v("idle_flag", int'(go0), 0);

        // Reset on the same cycle as a tick.
        step(1, 1, 0, 0, 0);
        for (int t = 0; t < 3; t++) tick_once(1);
        step(0, 1, 1, 1, 0);
        chk_g("rst_tick_image", gd0, init_img());
        chk_v("rst_tick_score", int'(sc0), 0);
        step(1, 0, 0, 0, 0);

        // Random traffic.
        for (int t = 0; t < 600; t++) begin
            step(1'($urandom_range(0, 99) != 0), 1'($urandom_range(0, 19) != 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 49) == 0));
        end

        // Long run to score saturation.
        step(0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        for (int t = 0; t < 65535; t++) step(1, 1, 1, 0, 0);
        chk_v("score_max", int'(sc0), 65535);
        step(1, 1, 1, 0, 0);
        chk_v("score_sat", int'(sc0), 65535);

        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        chk_v("sb0_drained", q0.size(), 0);
        chk_v("sb1_drained", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
